// File: rtl/scan_sequencer_if.sv
// -----------------------------------------------------------------------------
// scan_sequencer_if
//
// Bundles the host-side frame request/response signals and the four scan
// chain signals of the scan sequencer.
//
//   enable         host -> seq   run frames back-to-back while high
//   active_select  host -> seq   target design index (0 = nearest)
//   inputs         host -> seq   byte delivered to the target design
//   outputs        seq  -> host  last captured byte of the target
//   ready          seq  -> host  one-clk pulse when outputs updates
//   scan_clk_out   seq  -> chain chain clock
//   scan_data_out  seq  -> chain chain serial data
//   scan_select    seq  -> chain capture enable
//   scan_latch_en  seq  -> chain latch enable
//   scan_data_in   chain -> seq  chain tail data_out
//
// Modports: master = sequencer side, slave = host/chain side.
// -----------------------------------------------------------------------------
interface scan_sequencer_if #(
    parameter int NUM_IOS   = 8,
    parameter int SEL_WIDTH = 9
);
    logic                 enable;
    logic [SEL_WIDTH-1:0] active_select;
    logic [NUM_IOS-1:0]   inputs;
    logic [NUM_IOS-1:0]   outputs;
    logic                 ready;
    logic                 scan_clk_out;
    logic                 scan_data_out;
    logic                 scan_select;
    logic                 scan_latch_en;
    logic                 scan_data_in;

    modport master (
        input  enable, active_select, inputs, scan_data_in,
        output outputs, ready, scan_clk_out, scan_data_out, scan_select, scan_latch_en
    );

    modport slave (
        output enable, active_select, inputs, scan_data_in,
        input  outputs, ready, scan_clk_out, scan_data_out, scan_select, scan_latch_en
    );
endinterface

// File: rtl/scan_sequencer.sv
// -----------------------------------------------------------------------------
// scan_sequencer
//
// Frame sequencer at the head of the scan chain. Each frame shifts one byte
// into the selected design (SHIFT_IN), latches it (LATCH), captures the
// design's response (CAPTURE), shifts the chain back out while picking the
// target's bits off the tail (SHIFT_OUT) and presents the byte on
// bus.outputs with a one-clk bus.ready pulse (DONE).
//
// Ports:
//   clk    single clock
//   reset  asynchronous, active-high reset
//   bus    scan_sequencer_if.master (host request/response + chain signals)
//
// Optional feature, macro SCAN_LA_BYPASS_EN:
//   adds la_sel, la_scan_clk, la_scan_data, la_scan_select, la_scan_latch_en.
//   While la_sel is high the chain outputs follow the la_* inputs
//   combinationally, the FSM is held in IDLE (aborting any frame) and ready
//   stays low. Without the macro the chain is always FSM-driven.
// -----------------------------------------------------------------------------
module scan_sequencer #(
    parameter int NUM_DESIGNS = 25,
    parameter int NUM_IOS     = 8,
    parameter int SEL_WIDTH   = 9,
    parameter int HALF_PERIOD = 2
) (
    input  logic clk,
    input  logic reset,
    scan_sequencer_if.master bus
`ifdef SCAN_LA_BYPASS_EN
    ,
    input  logic la_sel,
    input  logic la_scan_clk,
    input  logic la_scan_data,
    input  logic la_scan_select,
    input  logic la_scan_latch_en
`endif
);

    localparam int PERIOD = 2 * HALF_PERIOD;
    localparam int PH_W   = $clog2(PERIOD);
    localparam int ELEM_W = (NUM_DESIGNS > 1) ? $clog2(NUM_DESIGNS) : 1;
    localparam int IB_W   = (NUM_IOS > 1) ? $clog2(NUM_IOS) : 1;

    localparam logic [PH_W-1:0]   PH_LAST     = PH_W'(PERIOD - 1);
    localparam logic [PH_W-1:0]   PH_PRE_RISE = PH_W'(HALF_PERIOD - 1);
    localparam logic [PH_W-1:0]   PH_HIGH     = PH_W'(HALF_PERIOD);
    localparam logic [ELEM_W-1:0] ELEM_FIRST  = ELEM_W'(NUM_DESIGNS - 1);
    localparam logic [IB_W-1:0]   IB_FIRST    = IB_W'(NUM_IOS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT_IN,
        ST_LATCH,
        ST_CAPTURE,
        ST_SHIFT_OUT,
        ST_DONE
    } state_t;

    state_t               state_reg, state_next;
    logic [PH_W-1:0]      phase_reg, phase_next;
    // Shift position is tracked as (element, bit-within-element), both
    // counting down: shift index n maps to element NUM_DESIGNS-1-n/NUM_IOS
    // and bit NUM_IOS-1-n%NUM_IOS, so a target hit is a plain compare.
    logic [ELEM_W-1:0]    elem_reg, elem_next;
    logic [IB_W-1:0]      ib_reg, ib_next;
    logic [SEL_WIDTH-1:0] sel_reg, sel_next;
    logic [NUM_IOS-1:0]   in_reg, in_next;
    logic [NUM_IOS-1:0]   capt_reg, capt_next;
    logic [NUM_IOS-1:0]   out_reg, out_next;
    logic                 ready_reg, ready_next;
    logic                 scan_clk_reg, scan_clk_next;
    logic                 scan_data_reg, scan_data_next;
    logic                 scan_sel_reg, scan_sel_next;
    logic                 latch_reg, latch_next;

    logic hold_idle;
    logic period_end;
    logic pre_rise;
    logic last_bit;
    logic target_hit;
    logic target_hit_next;
    logic frame_start;
    logic sample_en;
    logic advance_bit;
    logic clocking_next;

    assign period_end = (phase_reg == PH_LAST);
    assign pre_rise   = (phase_reg == PH_PRE_RISE);
    assign last_bit   = (elem_reg == '0) && (ib_reg == '0);
    // Out-of-range selects never match any element, so nothing is shifted in
    // and nothing is captured: the frame yields zero.
    assign target_hit      = (32'(elem_reg) == 32'(sel_reg));
    assign target_hit_next = (32'(elem_next) == 32'(sel_next));

    always_comb begin
        state_next  = state_reg;
        phase_next  = phase_reg;
        elem_next   = elem_reg;
        ib_next     = ib_reg;
        sel_next    = sel_reg;
        in_next     = in_reg;
        frame_start = 1'b0;
        sample_en   = 1'b0;
        advance_bit = 1'b0;

        if (state_reg != ST_IDLE && state_reg != ST_DONE) begin
            phase_next = period_end ? '0 : phase_reg + 1'b1;
        end

        case (state_reg)
            ST_IDLE: begin
                if (bus.enable) begin
                    frame_start = 1'b1;
                end
            end
            ST_SHIFT_IN: begin
                if (period_end) begin
                    if (last_bit) begin
                        state_next = ST_LATCH;
                    end else begin
                        advance_bit = 1'b1;
                    end
                end
            end
            ST_LATCH: begin
                if (period_end) begin
                    state_next = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (period_end) begin
                    state_next = ST_SHIFT_OUT;
                    elem_next  = ELEM_FIRST;
                    ib_next    = IB_FIRST;
                end
            end
            ST_SHIFT_OUT: begin
                // Sample on the clk edge that raises scan_clk_out; the tail
                // changed on the previous falling edge.
                sample_en = pre_rise && target_hit;
                if (period_end) begin
                    if (last_bit) begin
                        state_next = ST_DONE;
                    end else begin
                        advance_bit = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (bus.enable) begin
                    frame_start = 1'b1;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (advance_bit) begin
            if (ib_reg == '0) begin
                ib_next   = IB_FIRST;
                elem_next = elem_reg - 1'b1;
            end else begin
                ib_next = ib_reg - 1'b1;
            end
        end

        if (frame_start) begin
            state_next = ST_SHIFT_IN;
            phase_next = '0;
            elem_next  = ELEM_FIRST;
            ib_next    = IB_FIRST;
            sel_next   = bus.active_select;
            in_next    = bus.inputs;
        end

        if (hold_idle) begin
            state_next  = ST_IDLE;
            phase_next  = '0;
            frame_start = 1'b0;
            sample_en   = 1'b0;
        end

        // Chain outputs are registered from the next-state view so that they
        // line up with the state/phase registers. Data and select only change
        // at period boundaries, which is the edge driving scan_clk_out low.
        clocking_next  = (state_next == ST_SHIFT_IN) || (state_next == ST_CAPTURE) ||
                         (state_next == ST_SHIFT_OUT);
        scan_clk_next  = clocking_next && (phase_next >= PH_HIGH);
        scan_data_next = (state_next == ST_SHIFT_IN) && target_hit_next && in_next[ib_next];
        scan_sel_next  = (state_next == ST_CAPTURE);
        latch_next     = (state_next == ST_LATCH);
        ready_next     = (state_next == ST_DONE);
        out_next       = ((state_reg == ST_SHIFT_OUT) && (state_next == ST_DONE)) ? capt_reg : out_reg;
    end

    // Capture register: cleared at frame start, one bit written per hit.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_IOS; gi++) begin : g_capt
            assign capt_next[gi] = frame_start ? 1'b0 :
                                   ((sample_en && (ib_reg == IB_W'(gi))) ? bus.scan_data_in : capt_reg[gi]);
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            phase_reg     <= '0;
            elem_reg      <= '0;
            ib_reg        <= '0;
            sel_reg       <= '0;
            in_reg        <= '0;
            capt_reg      <= '0;
            out_reg       <= '0;
            ready_reg     <= 1'b0;
            scan_clk_reg  <= 1'b0;
            scan_data_reg <= 1'b0;
            scan_sel_reg  <= 1'b0;
            latch_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            phase_reg     <= phase_next;
            elem_reg      <= elem_next;
            ib_reg        <= ib_next;
            sel_reg       <= sel_next;
            in_reg        <= in_next;
            capt_reg      <= capt_next;
            out_reg       <= out_next;
            ready_reg     <= ready_next;
            scan_clk_reg  <= scan_clk_next;
            scan_data_reg <= scan_data_next;
            scan_sel_reg  <= scan_sel_next;
            latch_reg     <= latch_next;
        end
    end

    assign bus.outputs = out_reg;
    assign bus.ready   = ready_reg;

`ifdef SCAN_LA_BYPASS_EN
    assign hold_idle         = la_sel;
    assign bus.scan_clk_out  = la_sel ? la_scan_clk      : scan_clk_reg;
    assign bus.scan_data_out = la_sel ? la_scan_data     : scan_data_reg;
    assign bus.scan_select   = la_sel ? la_scan_select   : scan_sel_reg;
    assign bus.scan_latch_en = la_sel ? la_scan_latch_en : latch_reg;
`else
    assign hold_idle         = 1'b0;
    assign bus.scan_clk_out  = scan_clk_reg;
    assign bus.scan_data_out = scan_data_reg;
    assign bus.scan_select   = scan_sel_reg;
    assign bus.scan_latch_en = latch_reg;
`endif

endmodule

// File: tb/tb_scan_sequencer.sv
// -----------------------------------------------------------------------------
// tb_scan_sequencer
//
// Drives scan_sequencer against a behavioural 25-element scan chain (element 0
// returns the inverse of its latched byte, every other element loops back).
// A frame-level reference model (frame offset arithmetic) predicts every
// output each cycle; directed frames pin latency and results with literals,
// then a randomized back-to-back run exercises snapshotting and repeat rate.
// Macro SCAN_LA_BYPASS_EN enables the logic-analyzer bypass checks.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_scan_sequencer;

    localparam int ND      = 25;
    localparam int NI      = 8;
    localparam int SW      = 9;
    localparam int HP      = 2;
    localparam int PERIOD  = 2 * HP;
    localparam int TOT     = ND * NI;
    localparam int LAT     = PERIOD * (2 * TOT + 2);

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    scan_sequencer_if #(.NUM_IOS(NI), .SEL_WIDTH(SW)) bus ();

`ifdef SCAN_LA_BYPASS_EN
    logic la_sel = 1'b0;
    logic la_scan_clk = 1'b0;
    logic la_scan_data = 1'b0;
    logic la_scan_select = 1'b0;
    logic la_scan_latch_en = 1'b0;
    wire  tb_hold = la_sel;
`else
    wire  tb_hold = 1'b0;
`endif

    scan_sequencer #(
        .NUM_DESIGNS(ND), .NUM_IOS(NI), .SEL_WIDTH(SW), .HALF_PERIOD(HP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef SCAN_LA_BYPASS_EN
        ,
        .la_sel           (la_sel),
        .la_scan_clk      (la_scan_clk),
        .la_scan_data     (la_scan_data),
        .la_scan_select   (la_scan_select),
        .la_scan_latch_en (la_scan_latch_en)
`endif
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural scan chain ----------------
    // chain_bits[k*NI + b] is bit b of element k; new bits enter at index 0.
    logic [TOT-1:0] chain_bits = '0;
    logic [NI-1:0]  latched [ND];
    logic           tail = 1'b0;

    initial begin
        for (int k = 0; k < ND; k++) latched[k] = '0;
    end

    always @(posedge bus.scan_clk_out) begin
        if (bus.scan_select) begin
            for (int k = 0; k < ND; k++)
                chain_bits[k*NI +: NI] <= (k == 0) ? ~latched[k] : latched[k];
        end else begin
            chain_bits <= {chain_bits[TOT-2:0], bus.scan_data_out};
        end
    end

    always @(posedge clk) begin
        if (bus.scan_latch_en)
            for (int k = 0; k < ND; k++) latched[k] <= chain_bits[k*NI +: NI];
    end

    always @(negedge bus.scan_clk_out) tail <= chain_bits[TOT-1];
    assign bus.scan_data_in = tail;

    // ---------------- frame-level reference model ----------------
    function automatic logic [NI-1:0] exp_result(input int sel, input logic [NI-1:0] din);
        if (sel >= ND) return '0;
        if (sel == 0)  return ~din;
        return din;
    endfunction

    // {scan_clk, scan_data, scan_select, scan_latch_en} at frame offset t.
    function automatic logic [3:0] exp_chain(input bit busy, input int t, input int sel,
                                             input logic [NI-1:0] din);
        int p;
        int ph;
        logic c, d, s, l;
        c = 1'b0; d = 1'b0; s = 1'b0; l = 1'b0;
        if (busy) begin
            p  = t / PERIOD;
            ph = t % PERIOD;
            l  = (p == TOT);
            s  = (p == TOT + 1);
            c  = (p != TOT) && (ph >= HP);
            if (p < TOT && sel < ND && (p / NI) == (ND - 1 - sel))
                d = din[NI - 1 - (p % NI)];
        end
        return {c, d, s, l};
    endfunction

    bit            m_busy  = 1'b0;
    bit            m_done  = 1'b0;
    int            m_t     = 0;
    logic [SW-1:0] m_sel   = '0;
    logic [NI-1:0] m_in    = '0;
    logic [NI-1:0] m_out   = '0;
    logic          m_ready = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset || tb_hold) begin
            m_busy  <= 1'b0;
            m_done  <= 1'b0;
            m_t     <= 0;
            m_ready <= 1'b0;
            if (reset) m_out <= '0;
        end else begin
            m_ready <= 1'b0;
            if (m_busy) begin
                if (m_t + 1 == LAT) begin
                    m_busy  <= 1'b0;
                    m_done  <= 1'b1;
                    m_ready <= 1'b1;
                    m_out   <= exp_result(int'(m_sel), m_in);
                    m_t     <= 0;
                end else begin
                    m_t <= m_t + 1;
                end
            end else if (m_done || bus.enable) begin
                m_done <= 1'b0;
                if (bus.enable) begin
                    m_busy <= 1'b1;
                    m_t    <= 0;
                    m_sel  <= bus.active_select;
                    m_in   <= bus.inputs;
                end
            end
        end
    end

    logic [3:0] exp_c;
    assign exp_c = exp_chain(m_busy, m_t, int'(m_sel), m_in);

    always @(negedge clk) begin
        chk("ready", int'(bus.ready), int'(m_ready));
        chk("outputs", int'(bus.outputs), int'(m_out));
        if (!tb_hold) begin
            chk("scan_clk_out",  int'(bus.scan_clk_out),  int'(exp_c[3]));
            chk("scan_data_out", int'(bus.scan_data_out), int'(exp_c[2]));
            chk("scan_select",   int'(bus.scan_select),   int'(exp_c[1]));
            chk("scan_latch_en", int'(bus.scan_latch_en), int'(exp_c[0]));
        end
    end

    // ---------------- stimulus ----------------
    task automatic start_frame(input int sel, input logic [NI-1:0] din);
        @(negedge clk);
        bus.active_select = SW'(sel);
        bus.inputs        = din;
        bus.enable        = 1'b1;
        @(posedge clk);
        #1 bus.enable = 1'b0;
    endtask

    task automatic run_frame(input int sel, input logic [NI-1:0] din, input logic [NI-1:0] exp,
                             input int change_at, input logic [NI-1:0] din2);
        int  n;
        bit  got;
        n = 0;
        got = 1'b0;
        start_frame(sel, din);
        while (n < LAT + 200 && !got) begin
            @(posedge clk);
            n++;
            #1;
            if (n == change_at) bus.inputs = din2;
            if (bus.ready) got = 1'b1;
        end
        chk("frame_latency", got ? n : -1, LAT);
        chk("frame_result", int'(bus.outputs), int'(exp));
        $display("frame sel=%0d in=0x%02h out=0x%02h latency=%0d", sel, din, bus.outputs, n);
    endtask

    initial begin
        int cnt;
        int cyc;
        int last;
        bit got;
        reset             = 1'b1;
        bus.enable        = 1'b0;
        bus.active_select = '0;
        bus.inputs        = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", int'(bus.outputs), 0);
        chk("reset_ready", int'(bus.ready), 0);
        chk("reset_chain", int'({bus.scan_clk_out, bus.scan_data_out,
                                  bus.scan_select, bus.scan_latch_en}), 0);
        @(negedge clk) reset = 1'b0;

        cnt = 0;
        repeat (100) begin
            @(posedge clk);
            #1 if (bus.scan_clk_out) cnt++;
        end
        chk("idle_scan_clk_high_cycles", cnt, 0);

        run_frame(0, 8'hA5, 8'h5A, 0, 8'h00);
        run_frame(24, 8'h3C, 8'h3C, 500, 8'hFF);

        // Reset in the middle of SHIFT_IN.
        start_frame(0, 8'h11);
        repeat (299) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midreset_outputs", int'(bus.outputs), 0);
        chk("midreset_chain", int'({bus.scan_clk_out, bus.scan_data_out,
                                     bus.scan_select, bus.scan_latch_en}), 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        run_frame(0, 8'h0F, 8'hF0, 0, 8'h00);
        run_frame(30, 8'h77, 8'h00, 0, 8'h00);

        // Back-to-back randomized frames with enable held high.
        @(negedge clk);
        bus.active_select = SW'($urandom_range(0, 31));
        bus.inputs        = NI'($urandom);
        bus.enable        = 1'b1;
        cyc  = 0;
        last = -1;
        for (int f = 0; f < 6; f++) begin
            got = 1'b0;
            for (int w = 0; w < LAT + 200 && !got; w++) begin
                @(posedge clk);
                cyc++;
                #1;
                if (bus.ready) got = 1'b1;
                else if ($urandom_range(0, 199) == 0) begin
                    bus.active_select = SW'($urandom_range(0, 31));
                    bus.inputs        = NI'($urandom);
                end
            end
            chk("b2b_ready_seen", int'(got), 1);
            if (last >= 0) chk("repeat_interval", cyc - last, LAT + 1);
            last = cyc;
            $display("b2b frame %0d out=0x%02h at cycle %0d", f, bus.outputs, cyc);
        end
        bus.enable = 1'b0;
        repeat (4) @(posedge clk);

`ifdef SCAN_LA_BYPASS_EN
        start_frame(24, 8'h99);
        repeat (100) @(posedge clk);
        @(negedge clk) la_sel = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            la_scan_clk      = 1'($urandom);
            la_scan_data     = 1'($urandom);
            la_scan_select   = 1'($urandom);
            la_scan_latch_en = 1'($urandom);
            #1;
            chk("la_chain", int'({bus.scan_clk_out, bus.scan_data_out, bus.scan_select, bus.scan_latch_en}),
                int'({la_scan_clk, la_scan_data, la_scan_select, la_scan_latch_en}));
            chk("la_ready", int'(bus.ready), 0);
            $display("la pattern %0d clk=%0b data=%0b sel=%0b latch=%0b", i,
                     la_scan_clk, la_scan_data, la_scan_select, la_scan_latch_en);
        end
        repeat (LAT) @(posedge clk);
        #1 chk("la_no_ready_outputs", int'(bus.outputs), 0);
        @(negedge clk) la_sel = 1'b0;
        run_frame(5, 8'hC3, 8'hC3, 0, 8'h00);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
